// File: rtl/f_spsram_pkg.sv
// Shared lane width, init FSM state type and lane-count helper for the wide SPSRAM model.
package f_spsram_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic {ST_INIT, ST_RUN} spsram_st_e;

  function automatic int unsigned nlanes(input int unsigned dw);
    return dw / LANE_W;
  endfunction

endpackage

// File: rtl/f_spsram_lane.sv
// One byte lane of the SRAM array: synchronous write, read-first registered read.
module f_spsram_lane
  import f_spsram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 21
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LANE_W-1:0]     din,
  input  logic                  we,
  output logic [LANE_W-1:0]     dout
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/f_spsram_wide.sv
// Parametrised single-port SRAM with byte-lane writes, RD_LAT 1/2 read pipeline and QVALID.
// Define SPSRAM_INIT_EN to add a post-reset sweep that fills every word with INIT_VAL.
module f_spsram_wide
  import f_spsram_pkg::*;
#(
  parameter int unsigned     ADDR_WIDTH = 21,
  parameter int unsigned     DATA_WIDTH = 128,
  parameter int unsigned     RD_LAT     = 1,
  parameter logic [LANE_W-1:0] INIT_VAL = '0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           CEN,
  input  logic [nlanes(DATA_WIDTH)-1:0]  WEN,
  input  logic [ADDR_WIDTH-1:0]          A,
  input  logic [DATA_WIDTH-1:0]          D,
  output logic [DATA_WIDTH-1:0]          Q,
  output logic                           QVALID,
  output logic                           READY
);

  localparam int unsigned NL = nlanes(DATA_WIDTH);

  logic                  ready;
  logic                  accept;
  logic                  sweep;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [NL-1:0]         arr_we;
  logic [DATA_WIDTH-1:0] arr_din;
  logic [DATA_WIDTH-1:0] arr_dout;
  logic                  v1;

`ifdef SPSRAM_INIT_EN
  spsram_st_e            state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic                  ready_q, ready_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Sweep one word per cycle; the last word's write completes as we leave ST_INIT.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ready_d = 1'b0;
    case (state)
      ST_INIT: begin
        cnt_d = cnt + ADDR_WIDTH'(1);
        if (&cnt) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  assign sweep      = (state == ST_INIT);
  assign sweep_addr = cnt;
  assign ready      = ready_q;
`else
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
  assign ready      = 1'b1;
`endif

  assign READY  = ready;
  assign accept = !RST && !CEN && ready && !sweep;

  always_ff @(posedge CLK) begin
    if (RST)         addr_hold <= '0;
    else if (accept) addr_hold <= A;
  end

  // Sweep owns the array during init; otherwise the user access, else hold the last address.
  always_comb begin
    arr_addr = addr_hold;
    if (sweep)       arr_addr = sweep_addr;
    else if (accept) arr_addr = A;
    for (int unsigned i = 0; i < NL; i++) begin
      arr_we[i]                   = sweep | (accept & ~WEN[i]);
      arr_din[i*LANE_W +: LANE_W] = sweep ? INIT_VAL : D[i*LANE_W +: LANE_W];
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    f_spsram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk  (CLK),
      .addr (arr_addr),
      .din  (arr_din[g*LANE_W +: LANE_W]),
      .we   (arr_we[g]),
      .dout (arr_dout[g*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) v1 <= 1'b0;
    else     v1 <= accept;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] q2;
    logic                  v2;

    always_ff @(posedge CLK) begin
      if (RST) begin
        q2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) q2 <= arr_dout;
      end
    end

    assign Q      = q2;
    assign QVALID = v2;
  end else begin : g_lat1
    // Lane dout keeps following addr_hold after a write, so idle cycles show the held copy.
    logic [DATA_WIDTH-1:0] q_hold;

    always_ff @(posedge CLK) begin
      if (RST)     q_hold <= '0;
      else if (v1) q_hold <= arr_dout;
    end

    assign Q      = v1 ? arr_dout : q_hold;
    assign QVALID = v1;
  end

endmodule

// File: tb/tb_f_spsram_wide.sv
// Randomised bench for f_spsram_wide: RD_LAT=1 and RD_LAT=2 instances share stimulus and a word-level model.
module tb_f_spsram_wide;
  import f_spsram_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 128;
  localparam int unsigned NL    = DW / LANE_W;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          HMAX  = 4096;
  localparam logic [7:0]  IV    = 8'h5A;
`ifdef SPSRAM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b1;
  logic [NL-1:0] wen = '1;
  logic [AW-1:0] a   = '0;
  logic [DW-1:0] d   = '0;
  logic [DW-1:0] q1, q2;
  logic          qv1, qv2, rdy1, rdy2;

  always #5 clk = ~clk;

  f_spsram_wide #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .INIT_VAL(IV)) u_lat1 (
    .CLK(clk), .RST(rst), .CEN(cen), .WEN(wen), .A(a), .D(d),
    .Q(q1), .QVALID(qv1), .READY(rdy1));

  f_spsram_wide #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2), .INIT_VAL(IV)) u_lat2 (
    .CLK(clk), .RST(rst), .CEN(cen), .WEN(wen), .A(a), .D(d),
    .Q(q2), .QVALID(qv2), .READY(rdy2));

  // Word-level model: contents, which words are defined, and per-edge accepted read results.
  logic [DW-1:0] mem   [DEPTH];
  bit            known [DEPTH];
  bit            acc_h [HMAX];
  bit            kn_h  [HMAX];
  logic [DW-1:0] dat_h [HMAX];
  logic [DW-1:0] lastq [2];
  bit            lastk [2];
  int            init_left = 0;
  int            m = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {NL{b}};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step(input string tag, input logic r, input logic c,
                      input logic [NL-1:0] w, input logic [AW-1:0] ad, input logic [DW-1:0] dd);
    bit            acc;
    bit            v;
    int            k;
    logic [DW-1:0] nw;
    logic [DW-1:0] obs_q;
    logic          obs_v;
    rst = r; cen = c; wen = w; a = ad; d = dd;
    acc = !r && !c && (init_left == 0);
    @(posedge clk);
    m++;
    if (m >= HMAX) begin
      $display("FAIL cycle_budget: got %0d cycles limit %0d", m, HMAX);
      $fatal(1);
    end
    acc_h[m] = acc;
    kn_h[m]  = 1'b0;
    if (acc) begin
      dat_h[m] = mem[ad];
      kn_h[m]  = known[ad];
      nw = mem[ad];
      for (int i = 0; i < int'(NL); i++)
        if (!w[i]) nw[i*8 +: 8] = dd[i*8 +: 8];
      mem[ad] = nw;
      if (w == '0) known[ad] = 1'b1;
    end
    if (r) begin
      acc_h[m-1] = 1'b0;
      for (int l = 0; l < 2; l++) begin lastq[l] = '0; lastk[l] = 1'b1; end
      init_left = INIT_EN ? int'(DEPTH) : 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0)
        for (int i = 0; i < int'(DEPTH); i++) begin mem[i] = rep(IV); known[i] = 1'b1; end
    end
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      k     = m - l;
      v     = (k >= 1) && acc_h[k];
      obs_q = (l == 0) ? q1 : q2;
      obs_v = (l == 0) ? qv1 : qv2;
      check($sformatf("%s/lat%0d/qvalid", tag, l + 1), DW'(obs_v), DW'(v));
      if (v) begin
        if (kn_h[k]) check($sformatf("%s/lat%0d/q", tag, l + 1), obs_q, dat_h[k]);
        lastq[l] = dat_h[k];
        lastk[l] = kn_h[k];
      end else if (lastk[l]) begin
        check($sformatf("%s/lat%0d/qhold", tag, l + 1), obs_q, lastq[l]);
      end
    end
    check({tag, "/ready"}, DW'({rdy2, rdy1}), DW'({2{init_left == 0}}));
  endtask

  task automatic rand_step(input string tag, input bit force_cen);
    logic [NL-1:0] w;
    case ($urandom_range(2))
      0:       w = '0;
      1:       w = '1;
      default: w = NL'($urandom());
    endcase
    step(tag, 1'b0, force_cen ? 1'b0 : ($urandom_range(3) == 0), w, AW'($urandom()), rnd_word());
  endtask

  // Run until READY with stimulus that must be ignored; the sweep must take exactly DEPTH cycles.
  task automatic wait_ready(input string tag);
    int lowc = 0;
    while (!rdy1 && lowc < 40) begin
      rand_step({tag, "/ignored"}, 1'b1);
      lowc++;
    end
    if (INIT_EN) check({tag, "/ready_low_cycles"}, DW'(lowc), DW'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;
    for (int l = 0; l < 2; l++) begin lastq[l] = '0; lastk[l] = 1'b0; end

    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b1, '1, '0, '0);
    wait_ready("init");
    for (int i = 0; i < int'(DEPTH); i++) step("init_rd", 1'b0, 1'b0, '1, AW'(i), rnd_word());
    if (INIT_EN) begin
      for (int i = 0; i < 9; i++) rand_step("sweep9/ignored", 1'b1);
      step("sweep9/rst", 1'b1, 1'b0, '0, AW'(3), rnd_word());
      wait_ready("sweep9");
      for (int i = 0; i < int'(DEPTH); i++) step("sweep9_rd", 1'b0, 1'b0, '1, AW'(i), rnd_word());
    end

    for (int i = 0; i < int'(DEPTH); i++) step("fill", 1'b0, 1'b0, '0, AW'(i), rnd_word());

    step("t1_wr", 1'b0, 1'b0, '0, AW'(5), rep(8'hA5));
    step("t1_rd", 1'b0, 1'b0, '1, AW'(5), rnd_word());
    step("t1_idle", 1'b0, 1'b1, '1, '0, '0);
    step("t1_idle", 1'b0, 1'b1, '1, '0, '0);

    step("t2_wr", 1'b0, 1'b0, NL'(16'hFFFE), AW'(5), rep(8'h3C));
    step("t2_rd", 1'b0, 1'b0, '1, AW'(5), rnd_word());
    step("t2_idle", 1'b0, 1'b1, '1, '0, '0);
    step("t2_idle", 1'b0, 1'b1, '1, '0, '0);

    step("t3_wr_old", 1'b0, 1'b0, '0, AW'(7), rep(8'h11));
    step("t3_rdw", 1'b0, 1'b0, '0, AW'(7), rep(8'h22));
    step("t3_idle", 1'b0, 1'b1, '1, '0, '0);
    step("t3_rd", 1'b0, 1'b0, '1, AW'(7), rnd_word());
    step("t3_idle", 1'b0, 1'b1, '1, '0, '0);
    step("t3_idle", 1'b0, 1'b1, '1, '0, '0);

    for (int i = 1; i <= 3; i++) step("t4_b2b", 1'b0, 1'b0, '1, AW'(i), rnd_word());
    for (int i = 0; i < 5; i++) step("t4_idle", 1'b0, 1'b1, '1, AW'($urandom()), rnd_word());

    step("rst_mid/rd", 1'b0, 1'b0, '1, AW'(4), rnd_word());
    step("rst_mid/rst", 1'b1, 1'b0, '0, AW'(6), rnd_word());
    wait_ready("rst_mid");
    step("rst_mid/idle", 1'b0, 1'b1, '1, '0, '0);

    for (int i = 0; i < 300; i++) rand_step("rand", 1'b0);
    for (int i = 0; i < 3; i++) step("drain", 1'b0, 1'b1, '1, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
